// File: rtl/ram_pkg.sv
// Shared types and helpers for the RAM vector-add sequencer.
package ram_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } vec_state_t;

    // Largest legal element count for a given address width
    function automatic int unsigned max_len(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/ram_vec_add_ctrl.sv
// D[i] = A[i] + B[i] over a 3-port RAM, one element per cycle,
// read stage forwards the in-flight write so results match in-order execution.
module ram_vec_add_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] d_base,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  carry,
    output logic [ADDR_WIDTH-1:0] r_addr0,
    output logic [ADDR_WIDTH-1:0] r_addr1,
    input  logic [DATA_WIDTH-1:0] r_data0,
    input  logic [DATA_WIDTH-1:0] r_data1,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  write_enable
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned SUM_W = DATA_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(max_len(ADDR_WIDTH));

    vec_state_t            r_state,  w_state_nxt;
    logic [LEN_W-1:0]      r_idx,    w_idx_nxt;
    logic [LEN_W-1:0]      r_len,    w_len_nxt;
    logic [ADDR_WIDTH-1:0] r_ra0,    w_ra0_nxt;
    logic [ADDR_WIDTH-1:0] r_ra1,    w_ra1_nxt;
    logic [ADDR_WIDTH-1:0] r_da,     w_da_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr,  w_waddr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,  w_wdata_nxt;
    logic                  r_we,     w_we_nxt;
    logic                  r_busy,   w_busy_nxt;
    logic                  r_done,   w_done_nxt;
    logic                  r_carry,  w_carry_nxt;

    logic [LEN_W-1:0]      w_len_clamp;
    logic [DATA_WIDTH-1:0] w_op0;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [SUM_W-1:0]      w_sum;

    // Operand fetch with forwarding from the write being committed this cycle
    always_comb begin
        w_op0 = (r_we && (r_waddr == r_ra0)) ? r_wdata : r_data0;
        w_op1 = (r_we && (r_waddr == r_ra1)) ? r_wdata : r_data1;
        w_sum = SUM_W'(w_op0) + SUM_W'(w_op1);
        w_len_clamp = (len > MAX_LEN) ? MAX_LEN : len;
    end

    // Next-state and registered-output values
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_ra0_nxt   = r_ra0;
        w_ra1_nxt   = r_ra1;
        w_da_nxt    = r_da;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_carry_nxt = r_carry;
        w_we_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_nxt   = w_len_clamp;
                    w_idx_nxt   = '0;
                    w_ra0_nxt   = a_base;
                    w_ra1_nxt   = b_base;
                    w_da_nxt    = d_base;
                    w_carry_nxt = 1'b0;
                    if (w_len_clamp == '0) begin
                        w_state_nxt = S_FIN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_busy_nxt  = 1'b1;
                w_we_nxt    = 1'b1;
                w_waddr_nxt = r_da;
                w_wdata_nxt = w_sum[DATA_WIDTH-1:0];
                w_carry_nxt = r_carry | w_sum[DATA_WIDTH];
                if (r_idx == (r_len - LEN_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_idx_nxt = r_idx + LEN_W'(1);
                    w_ra0_nxt = r_ra0 + ADDR_WIDTH'(1);
                    w_ra1_nxt = r_ra1 + ADDR_WIDTH'(1);
                    w_da_nxt  = r_da + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_FIN;
                w_done_nxt  = 1'b1;
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_ra0   <= '0;
            r_ra1   <= '0;
            r_da    <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_ra0   <= w_ra0_nxt;
            r_ra1   <= w_ra1_nxt;
            r_da    <= w_da_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_we    <= w_we_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign carry        = r_carry;
    assign r_addr0      = r_ra0;
    assign r_addr1      = r_ra1;
    assign w_addr       = r_waddr;
    assign w_data       = r_wdata;
    assign write_enable = r_we;

endmodule

// File: tb/tb_ram_vec_add_ctrl.sv
// Bench for ram_vec_add_ctrl with a behavioural 8x8 3-port RAM attached.
module tb_ram_vec_add_ctrl;

    typedef logic [7:0][7:0] img_t;

    typedef struct {
        img_t       init;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] d;
        logic [3:0] l;
        img_t       exp_mem;
        logic       exp_c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] a_base = '0, b_base = '0, d_base = '0;
    logic [3:0] len = '0;
    logic       busy, done, carry, write_enable;
    logic [2:0] r_addr0, r_addr1, w_addr;
    logic [7:0] r_data0, r_data1, w_data;

    img_t ram = '0;
    img_t ld_img = '0;
    logic ld_req = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int ra_tr[16];
    int wa_tr[16];
    int ra_n, wa_n;

    ram_vec_add_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_base(a_base), .b_base(b_base), .d_base(d_base), .len(len),
        .busy(busy), .done(done), .carry(carry),
        .r_addr0(r_addr0), .r_addr1(r_addr1),
        .r_data0(r_data0), .r_data1(r_data1),
        .w_addr(w_addr), .w_data(w_data), .write_enable(write_enable)
    );

    always #5 clk = ~clk;

    // RAM: combinational reads, write on the clock edge; bench preload port
    always @(posedge clk) begin
        if (ld_req) ram <= ld_img;
        else if (write_enable) ram[w_addr] <= w_data;
    end
    assign r_data0 = ram[r_addr0];
    assign r_data1 = ram[r_addr1];

    function automatic img_t mk(input int b0, b1, b2, b3, b4, b5, b6, b7);
        img_t m;
        m[0] = 8'(b0); m[1] = 8'(b1); m[2] = 8'(b2); m[3] = 8'(b3);
        m[4] = 8'(b4); m[5] = 8'(b5); m[6] = 8'(b6); m[7] = 8'(b7);
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input img_t m);
        @(negedge clk);
        ld_img = m;
        ld_req = 1'b1;
        @(posedge clk);
        #1 ld_req = 1'b0;
    endtask

    // Launch one job and watch it cycle by cycle; cycle 1 is the cycle after acceptance
    task automatic run_job(input logic [2:0] a, b, d, input logic [3:0] l, input int glitch_cyc,
                           output int done_cyc, output int n_wr, output int win_err);
        int  n;
        bit  exp_busy, exp_we;
        n = (l > 4'd8) ? 8 : int'(l);
        @(negedge clk);
        a_base = a; b_base = b; d_base = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = -1; n_wr = 0; win_err = 0; ra_n = 0; wa_n = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            exp_busy = (n > 0) && (cyc <= n + 1);
            exp_we   = (n > 0) && (cyc >= 2) && (cyc <= n + 1);
            if (busy !== exp_busy || write_enable !== exp_we || (busy && done)) win_err++;
            if (write_enable === 1'b1) begin
                n_wr++;
                if (wa_n < 16) wa_tr[wa_n++] = int'(w_addr);
            end
            if (cyc <= n && ra_n < 16) ra_tr[ra_n++] = int'(r_addr0);
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            if (cyc == glitch_cyc) begin
                start = 1'b1; a_base = 3'd3; b_base = 3'd3; d_base = 3'd5; len = 4'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t tv[7];
    int   wrap_exp[4];

    initial begin
        int dc, nw, we_err, n, done_seen;
        img_t m;
        bit   c;
        logic [2:0] ra, rb, rd;
        logic [3:0] rl;

        tv[0] = '{mk(1,2,3,4,10,20,30,40), 3'd0, 3'd4, 3'd0, 4'd4, mk(11,22,33,44,10,20,30,40), 1'b0};
        tv[1] = '{mk(1,0,0,0,0,0,0,0),     3'd0, 3'd0, 3'd1, 4'd3, mk(1,2,4,8,0,0,0,0),         1'b0};
        tv[2] = '{mk(1,2,3,4,5,6,7,8),     3'd6, 3'd2, 3'd6, 4'd4, mk(6,8,3,4,5,6,10,12),       1'b0};
        tv[3] = '{mk(200,100,0,0,0,0,0,0), 3'd0, 3'd1, 3'd2, 4'd1, mk(200,100,44,0,0,0,0,0),    1'b1};
        tv[4] = '{mk(200,100,44,0,0,0,0,0),3'd2, 3'd2, 3'd3, 4'd1, mk(200,100,44,88,0,0,0,0),   1'b0};
        tv[5] = '{mk(1,2,3,4,5,6,7,8),     3'd0, 3'd1, 3'd2, 4'd0, mk(1,2,3,4,5,6,7,8),         1'b0};
        tv[6] = '{mk(1,1,1,1,1,1,1,1),     3'd0, 3'd1, 3'd1, 4'd9, mk(9,2,3,4,5,6,7,8),         1'b0};
        wrap_exp = '{6, 7, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_raddr", 64'({r_addr0, r_addr1}), 64'd0);
        chk("rst_wport", 64'({w_addr, w_data}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            n = (tv[i].l > 4'd8) ? 8 : int'(tv[i].l);
            load(tv[i].init);
            run_job(tv[i].a, tv[i].b, tv[i].d, tv[i].l, -1, dc, nw, we_err);
            chk($sformatf("t%0d_mem", i), 64'(ram), 64'(tv[i].exp_mem));
            chk($sformatf("t%0d_carry", i), 64'(carry), 64'(tv[i].exp_c));
            chk($sformatf("t%0d_done_cycle", i), 64'(dc), 64'((n == 0) ? 1 : n + 2));
            chk($sformatf("t%0d_writes", i), 64'(nw), 64'(n));
            chk($sformatf("t%0d_window", i), 64'(we_err), 64'd0);
            if (i == 2) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("wrap_raddr%0d", k), 64'(ra_tr[k]), 64'(wrap_exp[k]));
                    chk($sformatf("wrap_waddr%0d", k), 64'(wa_tr[k]), 64'(wrap_exp[k]));
                end
            end
        end

        // Start pulsed while busy must not disturb the running job
        load(tv[0].init);
        run_job(3'd0, 3'd4, 3'd0, 4'd4, 2, dc, nw, we_err);
        chk("glitch_mem", 64'(ram), 64'(tv[0].exp_mem));
        chk("glitch_done_cycle", 64'(dc), 64'd6);
        chk("glitch_writes", 64'(nw), 64'd4);

        // Reset in the middle of a job after two committed writes
        load(tv[0].init);
        @(negedge clk);
        a_base = 3'd0; b_base = 3'd4; d_base = 3'd0; len = 4'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_we", 64'(write_enable), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || write_enable === 1'b1) done_seen++;
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);
        chk("midrst_mem", 64'(ram), 64'(mk(11,22,3,4,10,20,30,40)));
        load(tv[0].init);
        run_job(3'd0, 3'd4, 3'd0, 4'd4, -1, dc, nw, we_err);
        chk("rerun_mem", 64'(ram), 64'(tv[0].exp_mem));
        chk("rerun_done_cycle", 64'(dc), 64'd6);
        chk("rerun_carry", 64'(carry), 64'd0);

        // Random jobs against a sequential element-by-element model
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 8; k++) m[k] = 8'($urandom_range(0, 255));
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            rd = 3'($urandom_range(0, 7));
            rl = 4'($urandom_range(0, 9));
            load(m);
            n = (rl > 4'd8) ? 8 : int'(rl);
            c = 1'b0;
            for (int i = 0; i < n; i++) begin
                int s;
                s = int'(m[(int'(ra) + i) % 8]) + int'(m[(int'(rb) + i) % 8]);
                m[(int'(rd) + i) % 8] = 8'(s);
                if (s > 255) c = 1'b1;
            end
            run_job(ra, rb, rd, rl, -1, dc, nw, we_err);
            chk($sformatf("rnd%0d_mem", t), 64'(ram), 64'(m));
            chk($sformatf("rnd%0d_carry", t), 64'(carry), 64'(c));
            chk($sformatf("rnd%0d_done_cycle", t), 64'(dc), 64'((n == 0) ? 1 : n + 2));
            chk($sformatf("rnd%0d_window", t), 64'(we_err), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_vec_add_ctrl.md
# ram_vec_add_ctrl

Initiator-side sequencer for the 3-port RAM: it drives both read-address ports and the write port, and consumes both read-data ports. On `start` it computes D[i] = A[i] + B[i] for i = 0..len-1, with A, B and D being base-addressed vectors in the same RAM. One element issues per cycle through a two-stage read/write pipeline with write-to-read forwarding, so results always equal strict element-by-element execution.

## Interface
- `ADDR_WIDTH`, default 3: RAM address width.
- `DATA_WIDTH`, default 8: RAM word width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a job; sampled only in IDLE.
- `a_base`, `b_base`, `d_base`  in  ADDR_WIDTH: vector base addresses, latched on an accepted start.
- `len`  in  ADDR_WIDTH+1: element count, latched on an accepted start; values above 2**ADDR_WIDTH are clamped to 2**ADDR_WIDTH.
- `busy`  out  1: job in progress.
- `done`  out  1: one-cycle completion pulse.
- `carry`  out  1: sticky; set if any element sum overflowed; cleared on an accepted start.
- `r_addr0`, `r_addr1`  out  ADDR_WIDTH: RAM read addresses for operands A and B.
- `r_data0`, `r_data1`  in  DATA_WIDTH: RAM read data, combinational from `r_addr0`/`r_addr1`.
- `w_addr`  out  ADDR_WIDTH, `w_data`  out  DATA_WIDTH, `write_enable`  out  1: RAM write port; the RAM writes on the clk edge.

## Operation
- **States:** IDLE, RUN, DRAIN, FIN.
  - IDLE → RUN on `start` with clamped len ≥ 1.
  - IDLE → FIN on `start` with len = 0.
  - RUN → DRAIN after element len-1 is read.
  - DRAIN → FIN.
  - FIN → IDLE.
- **Start handling:** `start` outside IDLE is ignored; base and length registers do not change.
- **Index counter:** `idx` counts 0..len-1 in RUN.
  - `r_addr0` = a_q + idx; `r_addr1` = b_q + idx.
  - All addresses wrap modulo 2**ADDR_WIDTH.
- **Read stage (RUN):** for each operand, if a write is pending this cycle (`write_enable`=1) and `w_addr` equals that read address, use `w_data` instead of the RAM data (forwarding). Each port is checked independently; both may forward at once.
- **Write stage:** the next cycle drives `write_enable`=1, `w_addr` = d_q + element index, `w_data` = (opA + opB) truncated to DATA_WIDTH.
- **Carry:** `carry` |= bit DATA_WIDTH of the full-width sum.
- **Outputs:** all outputs are driven from registers only; no combinational path from inputs to outputs.
- **Simultaneous events:** both read ports may hit the same address. A destination overlapping a source is legal; forwarding plus the in-order write guarantees sequential semantics.

## Timing
- Start is accepted at edge 0. Timeline for len = N ≥ 1:
  - Cycle 1: RUN, element 0 read.
  - Cycles 2..N+1: element k-2 written in cycle k.
  - Cycle N+1: DRAIN, last write.
  - Cycle N+2: FIN, `done`=1, `busy`=0.
- `busy` is high in cycles 1..N+1. `done` is never high concurrently with `busy`.
- len = 0: `done`=1 in cycle 1; `busy` and `write_enable` stay 0.
- Throughput: one element per cycle. The next start is accepted no earlier than the cycle after FIN.
- **Reset values:** state IDLE; `busy`, `done`, `carry`, `write_enable` = 0; `w_addr`, `w_data`, `idx`, base registers = 0, so `r_addr0` = `r_addr1` = 0.
- **Reset mid-job:** `write_enable` drops immediately (asynchronously). No `done` pulse is produced. Writes already committed stay in the RAM. The next start behaves normally.

## Structure
- Shared package `ram_pkg`:
  - state enum typedef `vec_state_t`;
  - FSM encodings;
  - localparam helper for the max length (2**ADDR_WIDTH).
- Single module, no sub-modules. The forwarding compare is two equality checks kept inline.
- The bench instantiates this block with the team's 3-port RAM, connected port-to-port.

## Test plan
All scenarios use ADDR_WIDTH=3, DATA_WIDTH=8.
1. mem[0..3]={1,2,3,4}, mem[4..7]={10,20,30,40}; a=0, b=4, d=0, len=4 → writes in cycles 2..5 to addr 0..3 with data 11,22,33,44; `done` in cycle 6; `carry`=0.
2. Forwarding: mem[0]=1; a=0, b=0, d=1, len=3 → mem[1]=2, mem[2]=4, mem[3]=8. Elements 1 and 2 must take both operands from `w_data`.
3. Wrap: a=6, b=2, d=6, len=4 → `r_addr0` sequence 6,7,0,1; `w_addr` sequence 6,7,0,1; no spurious writes outside cycles 2..5.
4. Overflow: mem[0]=200, mem[1]=100; a=0, b=1, d=2, len=1 → mem[2]=44, `carry`=1. A following job with no overflow clears `carry` to 0.
5. Corner inputs:
   - len=0 → `done` in cycle 1, no write.
   - len=9 → clamped to 8 writes.
   - `start` pulsed while `busy` → ignored; bases unchanged.
6. `rst` asserted mid-cycle after 2 of 4 writes → `write_enable` falls immediately, no `done`, mem holds 2 results. Re-running scenario 1 afterwards passes.
